// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
// cmd_t is sized to the default memory geometry used by mem_arbiter.
package mem_arb_pkg;

   localparam int CMD_ADDR_W = 4;
   localparam int CMD_DATA_W = 32;

   typedef struct packed {
      logic                  we;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } cmd_t;

   // Requester tag width; a lone requester still needs one tag bit.
   function automatic int tag_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: the first set request after i_ptr wins.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 1
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_en,
   input  logic [TAG_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [TAG_W-1:0]   o_idx,
   output logic               o_any
);

   logic [TAG_W-1:0] w_cand;
   logic             w_found;

   // Walk ptr+1, ptr+2, ... modulo NUM_REQ so the last winner has lowest priority.
   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_cand  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand = TAG_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_en && !w_found && i_req[w_cand]) begin
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
            w_found       = 1'b1;
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters,
// with an issue stage, a memory stage and a tagged in-order read return.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = CMD_DATA_W,
   parameter int ADDR_WIDTH = CMD_ADDR_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   input  logic                          arb_en,
   output logic                          mem_write_en,
   output logic                          mem_read_en,
   output logic [ADDR_WIDTH-1:0]         mem_address,
   output logic [DATA_WIDTH-1:0]         mem_data_in,
   input  logic                          mem_valid_out,
   input  logic [DATA_WIDTH-1:0]         mem_data_out
);

   localparam int TAG_W = tag_width(NUM_REQ);

   logic [NUM_REQ-1:0]    w_gnt;
   logic [TAG_W-1:0]      w_idx;
   logic                  w_accept;
   logic                  w_arb_en;
   cmd_t                  w_cmd;

   logic                  r_mem_we;
   logic                  r_mem_re;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_din;
   logic                  r_iss_pend;
   logic [TAG_W-1:0]      r_iss_tag;
   logic                  r_ret_pend;
   logic [TAG_W-1:0]      r_ret_tag;
   logic [TAG_W-1:0]      r_rr_ptr;

   assign w_arb_en = arb_en & ~reset;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TAG_W   (TAG_W)
   ) u_rr (
      .i_req   (req),
      .i_en    (w_arb_en),
      .i_ptr   (r_rr_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_any   (w_accept)
   );

   assign gnt = w_gnt;

   always_comb begin
      w_cmd.we    = req_we[w_idx];
      w_cmd.addr  = req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_cmd.wdata = req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
   end

   // Issue stage drives the memory directly; the pend/tag pair rides one stage
   // behind so it lines up with the memory's registered read response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem_we   <= 1'b0;
         r_mem_re   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_din  <= '0;
         r_iss_pend <= 1'b0;
         r_iss_tag  <= '0;
         r_ret_pend <= 1'b0;
         r_ret_tag  <= '0;
         r_rr_ptr   <= TAG_W'(NUM_REQ - 1);
      end else begin
         r_ret_pend <= r_iss_pend;
         r_ret_tag  <= r_iss_tag;
         if (w_accept) begin
            r_mem_we   <= w_cmd.we;
            r_mem_re   <= ~w_cmd.we;
            r_mem_addr <= w_cmd.addr;
            r_mem_din  <= w_cmd.we ? w_cmd.wdata : '0;
            r_iss_pend <= ~w_cmd.we;
            r_iss_tag  <= w_idx;
            r_rr_ptr   <= w_idx;
         end else begin
            r_mem_we   <= 1'b0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_iss_pend <= 1'b0;
         end
      end
   end

   assign mem_write_en = r_mem_we;
   assign mem_read_en  = r_mem_re;
   assign mem_address  = r_mem_addr;
   assign mem_data_in  = r_mem_din;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ret
      assign rvalid[gi] = mem_valid_out & r_ret_pend & ~reset & (r_ret_tag == TAG_W'(gi));
   end

   assign rdata = (|rvalid) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table followed by
// random traffic, both checked against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [DW-1:0]   rdata;
   logic            arb_en;
   logic            mem_write_en;
   logic            mem_read_en;
   logic [AW-1:0]   mem_address;
   logic [DW-1:0]   mem_data_in;
   logic            mem_valid_out;
   logic [DW-1:0]   mem_data_out;

   mem_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .arb_en(arb_en),
      .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_valid_out(mem_valid_out), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Single-port memory with a one-cycle registered read, cleared by reset.
   logic [DW-1:0] memArr [16];
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_valid_out <= 1'b0;
         mem_data_out  <= '0;
         for (int i = 0; i < 16; i++) memArr[i] <= '0;
      end else begin
         mem_valid_out <= mem_read_en;
         mem_data_out  <= mem_read_en ? memArr[mem_address] : '0;
         if (mem_write_en) memArr[mem_address] <= mem_data_in;
      end
   end

   typedef struct {
      logic          rst;
      logic          en;
      logic [N-1:0]  rq;
      logic [N-1:0]  we;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [N-1:0]  expGnt;
      logic [N-1:0]  expRv;
      logic [DW-1:0] expRdata;
   } vec_t;

   typedef struct {
      int            tag;
      logic [DW-1:0] data;
      int            due;
   } rd_t;

   int checks = 0;
   int errors = 0;

   // Reference model state: previous acceptance, memory image, outstanding reads.
   int            cyc = 0;
   int            mPtr = N - 1;
   logic [DW-1:0] mMem [16];
   logic          accV = 1'b0;
   logic          accWe = 1'b0;
   logic [AW-1:0] accAddr = '0;
   logic [DW-1:0] accData = '0;
   int            accTag = 0;
   int            lastWinner = -1;
   rd_t           pendQ [$];
   vec_t          vecs [$];

   logic          cV [N];
   logic          cWe [N];
   logic [AW-1:0] cA [N];
   logic [DW-1:0] cD [N];

   function automatic vec_t mk(logic rst, logic en, logic [N-1:0] rq, logic [N-1:0] we,
                               logic [AW-1:0] a0, logic [AW-1:0] a1, logic [DW-1:0] d0,
                               logic [DW-1:0] d1, logic [N-1:0] eg, logic [N-1:0] er,
                               logic [DW-1:0] ed);
      vec_t v;
      v.rst = rst; v.en = en; v.rq = rq; v.we = we; v.a0 = a0; v.a1 = a1;
      v.d0 = d0; v.d1 = d1; v.expGnt = eg; v.expRv = er; v.expRdata = ed;
      return v;
   endfunction

   function automatic int refWinner(logic rst, logic en, logic [N-1:0] rq, int ptr);
      if (rst || !en) return -1;
      for (int k = 1; k <= N; k++) begin
         if (rq[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic en, input logic [N-1:0] rq,
                                input logic [N-1:0] we, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [DW-1:0] d0,
                                input logic [DW-1:0] d1);
      reset     = rst;
      arb_en    = en;
      req       = rq;
      req_we    = we;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   task automatic modelCheck();
      int            w;
      logic [N-1:0]  eGnt;
      logic [N-1:0]  eRv;
      logic [DW-1:0] eRd;
      logic          live;
      w    = refWinner(reset, arb_en, req, mPtr);
      eGnt = (w >= 0) ? N'(1 << w) : '0;
      eRv  = '0;
      eRd  = '0;
      if (!reset && pendQ.size() > 0 && pendQ[0].due == cyc) begin
         eRv = N'(1 << pendQ[0].tag);
         eRd = pendQ[0].data;
         void'(pendQ.pop_front());
      end
      live = accV && !reset;
      checkOutput("gnt", 64'(gnt), 64'(eGnt));
      checkOutput("rvalid", 64'(rvalid), 64'(eRv));
      checkOutput("rdata", 64'(rdata), 64'(eRd));
      checkOutput("mem_write_en", 64'(mem_write_en), 64'(live && accWe));
      checkOutput("mem_read_en", 64'(mem_read_en), 64'(live && !accWe));
      checkOutput("mem_address", 64'(mem_address), live ? 64'(accAddr) : 64'd0);
      checkOutput("mem_data_in", 64'(mem_data_in), (live && accWe) ? 64'(accData) : 64'd0);
   endtask

   task automatic modelEdge();
      int w;
      lastWinner = -1;
      if (reset) begin
         pendQ.delete();
         accV = 1'b0;
         mPtr = N - 1;
         for (int i = 0; i < 16; i++) mMem[i] = '0;
      end else begin
         if (accV) begin
            if (accWe) mMem[accAddr] = accData;
            else pendQ.push_back('{accTag, mMem[accAddr], cyc + 1});
         end
         w = refWinner(reset, arb_en, req, mPtr);
         accV = (w >= 0);
         if (w >= 0) begin
            accWe      = req_we[w];
            accAddr    = req_addr[w*AW +: AW];
            accData    = req_wdata[w*DW +: DW];
            accTag     = w;
            mPtr       = w;
            lastWinner = w;
         end
      end
      cyc++;
   endtask

   task automatic runCycle(input bit useTab, input vec_t v);
      @(negedge clk);
      modelCheck();
      if (useTab) begin
         checkOutput("tab_gnt", 64'(gnt), 64'(v.expGnt));
         checkOutput("tab_rvalid", 64'(rvalid), 64'(v.expRv));
         checkOutput("tab_rdata", 64'(rdata), 64'(v.expRdata));
      end
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic newCmd(input int i);
      cV[i]  = ($urandom_range(0, 3) != 0);
      cWe[i] = $urandom_range(0, 1) == 1;
      cA[i]  = AW'($urandom_range(0, 15));
      cD[i]  = $urandom;
   endtask

   initial begin
      vec_t dummy;
      dummy = mk(0, 0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
      for (int i = 0; i < 16; i++) mMem[i] = '0;
      applyStimulus(1'b1, 1'b1, 2'b01, 2'b00, 4'h0, 4'h0, '0, '0);

      // reset, single write/read, read-after-write, fairness, freeze, reset mid-read
      for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 4'h0, 4'h0, 0, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b01, 4'h3, 4'h0, 32'hDEADBEEF, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 4'h3, 4'h0, 0, 0, 2'b01, 2'b01, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF));
      vecs.push_back(mk(0, 1, 2'b10, 2'b10, 4'h0, 4'hF, 0, 32'h12345678, 2'b10, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 4'hF, 4'h0, 0, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 32'h12345678));
      vecs.push_back(mk(0, 1, 2'b10, 2'b00, 4'h0, 4'h3, 0, 0, 2'b10, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b10, 2'b10, 32'hDEADBEEF));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b01, 32'hDEADBEEF));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b10, 2'b10, 32'h12345678));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b01, 32'hDEADBEEF));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b10, 2'b10, 32'h12345678));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b01, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b00, 2'b10, 32'h12345678));
      vecs.push_back(mk(0, 0, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 0, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b10, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b01, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b11, 2'b00, 4'h3, 4'hF, 0, 0, 2'b01, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      vecs.push_back(mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2'b01, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].rq, vecs[i].we,
                       vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         runCycle(1'b1, vecs[i]);
      end

      // Random traffic: requesters hold a command until the model says it was taken.
      for (int i = 0; i < N; i++) newCmd(i);
      for (int c = 0; c < 500; c++) begin
         logic          rst;
         logic [N-1:0]  rq;
         logic [N-1:0]  we;
         rst = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < N; i++) begin
            rq[i] = cV[i];
            we[i] = cWe[i];
         end
         applyStimulus(rst, $urandom_range(0, 7) != 0, rq, we, cA[0], cA[1], cD[0], cD[1]);
         runCycle(1'b0, dummy);
         if (lastWinner >= 0) newCmd(lastWinner);
         for (int i = 0; i < N; i++) if (!cV[i] && $urandom_range(0, 1) == 1) newCmd(i);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
